branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Backend end of the branch predictor update interface; sits at the end of the execute stage.
- Takes resolved control-flow instructions (conditional branch, jal, jalr) with the prediction that travelled down the pipe, and computes the actual outcome.
- Classifies call/return, detects mispredicts, and emits the per-instruction predictor update (BTB/PHT/RAS fields) plus a frontend redirect.
- Holds a 1-bit epoch so wrong-path instructions arriving after a mispredict are dropped.

Parameters:
- XLEN, 32, address/data width.
- STAT_WIDTH, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  resolved control-flow instruction present this cycle
- ex_pc  in  XLEN  instruction pc
- ex_epoch  in  1  epoch tag captured at fetch
- ex_kind  in  2  00 branch, 01 jal, 10 jalr, 11 reserved (input ignored)
- ex_cond_taken  in  1  branch comparison result (branch only)
- ex_target  in  XLEN  computed target (jalr with bit0 already cleared)
- ex_rd, ex_rs1  in  5  register indices
- ex_pred_valid  in  1  frontend predicted taken
- ex_pred_target  in  XLEN  frontend predicted target
- ext_flush  in  1  older flush (exception/trap) from commit
- upd_valid  out  1  predictor update valid
- upd_pc  out  XLEN  instruction pc (BTB/PHT index)
- upd_link_pc  out  XLEN  pc+4 (RAS push value)
- upd_actual_target, upd_actual_taken, upd_is_miss_predict  out  XLEN,1,1  resolved outcome
- upd_btb_type  out  2  00 BRANCH, 01 JUMP, 10 CALL, 11 RETURN
- upd_is_branch_inst, upd_is_call_inst, upd_is_ret_inst, upd_same_link_regs  out  1 each
- redirect_valid  out  1  single-cycle frontend flush request
- redirect_pc  out  XLEN  correct next pc
- cur_epoch  out  1  current epoch, fed to fetch
- stat_ctrl, stat_miss  out  STAT_WIDTH  accepted control-flow count / mispredict count

Behaviour:
- Reset: all outputs 0, cur_epoch 0, counters 0. Reset mid-operation discards any registered result; no upd_valid or redirect_valid in the following cycle.
- Accept condition in cycle N: ex_valid && ex_kind!=11 && ex_epoch==cur_epoch && !ext_flush. Non-accepted inputs have no effect at all.
- Link reg: x1 or x5.
- call = kind in {jal,jalr} && rd is link.
- ret = kind==jalr && rs1 is link && !(call && rd==rs1).
- same_link_regs = call && rs1 is link && rd==rs1.
  - Net effect: rd==rs1 link gives a push only.
  - rd!=rs1 (both link) gives call=ret=1, i.e. pop-then-push.
- btb_type: branch gives BRANCH; ret && !call gives RETURN; call gives CALL; otherwise JUMP.
- actual_taken = kind==branch ? ex_cond_taken : 1.
- actual_next = actual_taken ? ex_target : pc+4.
- pred_next = ex_pred_valid ? ex_pred_target : pc+4.
- miss = pred_next != actual_next. This is a full 32-bit compare; pc+4 wraps mod 2^32.
- upd_actual_target = ex_target. It is valid even for a not-taken branch.
- Latency: one cycle. Fields are registered at the edge ending cycle N; upd_valid is a 1-cycle pulse in N+1.
- redirect_valid=1 in N+1 iff miss, with redirect_pc=actual_next.
- Epoch: on that same edge, cur_epoch toggles iff accepted && miss. Inputs in N+1 carrying the old epoch are dropped.
- ext_flush in cycle N:
  - Cycle N's input is dropped.
  - cur_epoch toggles exactly once, even if a mispredict was also present.
  - No redirect from this unit.
  - Output registered in N−1 still appears in N (it is older than the flush).
- No backpressure; one instruction per cycle, back-to-back.
- Counters: stat_ctrl +1 per accepted instruction; stat_miss +1 per accepted miss. Both saturate at all-ones.

Test Plan:
- Branch pc=0x1000, cond_taken=1, target=0x0F00, pred_valid=0 -> N+1: upd_valid=1, taken=1, miss=1, type=00, redirect_pc=0x0F00, cur_epoch 0->1.
- Branch same pc, cond_taken=0, pred_valid=0 -> miss=0, no redirect, epoch unchanged, stat_ctrl+1, stat_miss unchanged.
- Call/return classification:
  - jal rd=x1 pc=0x2000 target 0x3000, pred correct -> call=1, ret=0, type=10, link_pc=0x2004, miss=0.
  - jalr rs1=x1 rd=x0 target 0x2004, pred_target 0x2008 -> type=11, ret=1, miss=1, redirect_pc=0x2004.
  - jalr rs1=x5 rd=x1 -> call=ret=1, same_link_regs=0, type=10.
  - jalr rs1=x1 rd=x1 -> call=1, ret=0, same_link_regs=1.
- Mispredict in N, then epoch-0 instruction in N+1 -> dropped (no upd_valid in N+2). Epoch-1 instruction in N+2 -> accepted.
- ext_flush asserted together with a mispredicting input -> no upd_valid, no redirect, epoch toggles once. Counter preset to all-ones via a long run: saturates, no wrap.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Execute-to-resolve bus: resolved control-flow instruction in, predictor update and redirect out.
// Valid-only semantics: ex_valid, upd_valid and redirect_valid each qualify their fields for exactly one cycle; there is no ready, so the receiver must take every beat.
interface branch_resolve_if #(
   parameter int XLEN = 32
);
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic            ex_epoch;
   logic [1:0]      ex_kind;
   logic            ex_cond_taken;
   logic [XLEN-1:0] ex_target;
   logic [4:0]      ex_rd;
   logic [4:0]      ex_rs1;
   logic            ex_pred_valid;
   logic [XLEN-1:0] ex_pred_target;

   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic [XLEN-1:0] upd_link_pc;
   logic [XLEN-1:0] upd_actual_target;
   logic            upd_actual_taken;
   logic            upd_is_miss_predict;
   logic [1:0]      upd_btb_type;
   logic            upd_is_branch_inst;
   logic            upd_is_call_inst;
   logic            upd_is_ret_inst;
   logic            upd_same_link_regs;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output ex_valid, ex_pc, ex_epoch, ex_kind, ex_cond_taken, ex_target,
             ex_rd, ex_rs1, ex_pred_valid, ex_pred_target,
      input  upd_valid, upd_pc, upd_link_pc, upd_actual_target, upd_actual_taken,
             upd_is_miss_predict, upd_btb_type, upd_is_branch_inst, upd_is_call_inst,
             upd_is_ret_inst, upd_same_link_regs, redirect_valid, redirect_pc
   );

   modport slave (
      input  ex_valid, ex_pc, ex_epoch, ex_kind, ex_cond_taken, ex_target,
             ex_rd, ex_rs1, ex_pred_valid, ex_pred_target,
      output upd_valid, upd_pc, upd_link_pc, upd_actual_target, upd_actual_taken,
             upd_is_miss_predict, upd_btb_type, upd_is_branch_inst, upd_is_call_inst,
             upd_is_ret_inst, upd_same_link_regs, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branch/jal/jalr outcomes, classifies call/return, flags mispredicts and emits
// a registered predictor update plus frontend redirect, dropping wrong-epoch instructions.
module branch_resolve_unit #(
   parameter int XLEN       = 32,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   branch_resolve_if.slave       bus,
   input  logic                  ext_flush,
   output logic                  cur_epoch,
   output logic [STAT_WIDTH-1:0] stat_ctrl,
   output logic [STAT_WIDTH-1:0] stat_miss
);
   localparam logic [1:0] KIND_BRANCH = 2'b00;
   localparam logic [1:0] KIND_JAL    = 2'b01;
   localparam logic [1:0] KIND_JALR   = 2'b10;
   localparam logic [1:0] KIND_RSVD   = 2'b11;
   localparam logic [1:0] BTB_BRANCH  = 2'b00;
   localparam logic [1:0] BTB_JUMP    = 2'b01;
   localparam logic [1:0] BTB_CALL    = 2'b10;
   localparam logic [1:0] BTB_RETURN  = 2'b11;
   localparam logic [XLEN-1:0]       PC_STEP  = XLEN'(4);
   localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

   logic            accept, rd_link, rs1_link, is_call, is_ret, same_link, taken, miss;
   logic [1:0]      btb_type;
   logic [XLEN-1:0] link_pc, actual_next, pred_next;

   assign accept    = bus.ex_valid && (bus.ex_kind != KIND_RSVD) &&
                      (bus.ex_epoch == cur_epoch) && !ext_flush;
   assign rd_link   = (bus.ex_rd  == 5'd1) || (bus.ex_rd  == 5'd5);
   assign rs1_link  = (bus.ex_rs1 == 5'd1) || (bus.ex_rs1 == 5'd5);
   assign is_call   = ((bus.ex_kind == KIND_JAL) || (bus.ex_kind == KIND_JALR)) && rd_link;
   // rd==rs1 on a link register is a plain push; distinct link regs pop then push.
   assign is_ret    = (bus.ex_kind == KIND_JALR) && rs1_link && !(is_call && (bus.ex_rd == bus.ex_rs1));
   assign same_link = is_call && rs1_link && (bus.ex_rd == bus.ex_rs1);

   assign taken       = (bus.ex_kind == KIND_BRANCH) ? bus.ex_cond_taken : 1'b1;
   assign link_pc     = bus.ex_pc + PC_STEP;
   assign actual_next = taken ? bus.ex_target : link_pc;
   assign pred_next   = bus.ex_pred_valid ? bus.ex_pred_target : link_pc;
   assign miss        = (pred_next != actual_next);

   always_comb begin
      btb_type = BTB_JUMP;
      if (bus.ex_kind == KIND_BRANCH) btb_type = BTB_BRANCH;
      else if (is_ret && !is_call)    btb_type = BTB_RETURN;
      else if (is_call)               btb_type = BTB_CALL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.upd_valid           <= 1'b0;
         bus.upd_pc              <= '0;
         bus.upd_link_pc         <= '0;
         bus.upd_actual_target   <= '0;
         bus.upd_actual_taken    <= 1'b0;
         bus.upd_is_miss_predict <= 1'b0;
         bus.upd_btb_type        <= BTB_BRANCH;
         bus.upd_is_branch_inst  <= 1'b0;
         bus.upd_is_call_inst    <= 1'b0;
         bus.upd_is_ret_inst     <= 1'b0;
         bus.upd_same_link_regs  <= 1'b0;
         bus.redirect_valid      <= 1'b0;
         bus.redirect_pc         <= '0;
         cur_epoch               <= 1'b0;
         stat_ctrl               <= '0;
         stat_miss               <= '0;
      end else begin
         bus.upd_valid      <= accept;
         bus.redirect_valid <= accept && miss;
         if (accept) begin
            bus.upd_pc              <= bus.ex_pc;
            bus.upd_link_pc         <= link_pc;
            bus.upd_actual_target   <= bus.ex_target;
            bus.upd_actual_taken    <= taken;
            bus.upd_is_miss_predict <= miss;
            bus.upd_btb_type        <= btb_type;
            bus.upd_is_branch_inst  <= (bus.ex_kind == KIND_BRANCH);
            bus.upd_is_call_inst    <= is_call;
            bus.upd_is_ret_inst     <= is_ret;
            bus.upd_same_link_regs  <= same_link;
            bus.redirect_pc         <= actual_next;
            if (stat_ctrl != '1) stat_ctrl <= stat_ctrl + STAT_ONE;
            if (miss && (stat_miss != '1)) stat_miss <= stat_miss + STAT_ONE;
         end
         // An older flush owns the epoch change; a same-cycle mispredict must not toggle it again.
         if (ext_flush || (accept && miss)) cur_epoch <= ~cur_epoch;
      end
   end
endmodule
